// File: rtl/wb_unit.sv
// wb_unit: writeback unit selecting ALU/load/pc+4/imm results and driving a registered
// register-file write, with load alignment, sign/zero extension and a memory timeout.
module wb_unit #(
    parameter int CPU_WIDTH = 32,
    parameter int TIMEOUT   = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ex_valid,
    output logic                 ex_ready,
    input  logic                 ex_reg_wen,
    input  logic [4:0]           ex_rd_idx,
    input  logic [1:0]           ex_wb_sel,
    input  logic [CPU_WIDTH-1:0] ex_alu_res,
    input  logic [CPU_WIDTH-1:0] ex_imm,
    input  logic [CPU_WIDTH-1:0] ex_pc,
    input  logic [2:0]           ex_funct3,
    input  logic                 mem_rvalid,
    input  logic [CPU_WIDTH-1:0] mem_rdata,
    output logic                 reg_wen,
    output logic [4:0]           reg_waddr,
    output logic [CPU_WIDTH-1:0] reg_wdata,
    output logic                 misalign_err,
    output logic                 bus_err
);
    typedef enum logic {IDLE, WAIT_MEM} state_t;

    state_t state, state_n;
    logic [7:0] cnt;
    logic [4:0] rd_q;
    logic       wen_q;
    logic [2:0] f3_q;
    logic [1:0] a_q;

    logic                 accept, is_mem, mis, timeout_hit, load_wr, alu_wr;
    logic [7:0]           byte_v;
    logic [15:0]          half_v;
    logic [CPU_WIDTH-1:0] load_v, direct_v;

    assign ex_ready    = state == IDLE;
    assign accept      = ex_valid && ex_ready;
    assign is_mem      = ex_wb_sel == 2'd1;
    assign timeout_hit = state == WAIT_MEM && !mem_rvalid && cnt == 8'(TIMEOUT - 1);
    assign load_wr     = state == WAIT_MEM && mem_rvalid && wen_q && rd_q != 5'd0;
    assign alu_wr      = accept && !is_mem && ex_reg_wen && ex_rd_idx != 5'd0;

    always_comb begin
        mis = 1'b1;
        case (ex_funct3)
            3'b000, 3'b100: mis = 1'b0;
            3'b001, 3'b101: mis = ex_alu_res[0];
            3'b010:         mis = ex_alu_res[1:0] != 2'b00;
            default:        mis = 1'b1;
        endcase
    end

    assign direct_v = ex_wb_sel == 2'd0 ? ex_alu_res :
                      ex_wb_sel == 2'd2 ? ex_pc + CPU_WIDTH'(4) : ex_imm;

    // funct3[2] marks the unsigned loads, so it gates the extension bit
    assign byte_v = mem_rdata[{a_q, 3'b000} +: 8];
    assign half_v = mem_rdata[{a_q[1], 4'b0000} +: 16];
    assign load_v = f3_q[1:0] == 2'b00 ? {{(CPU_WIDTH-8){~f3_q[2] & byte_v[7]}}, byte_v} :
                    f3_q[1:0] == 2'b01 ? {{(CPU_WIDTH-16){~f3_q[2] & half_v[15]}}, half_v} :
                    mem_rdata;

    always_comb begin
        state_n = state;
        if (state == IDLE && accept && is_mem && !mis)
            state_n = WAIT_MEM;
        else if (state == WAIT_MEM && (mem_rvalid || timeout_hit))
            state_n = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            rd_q         <= '0;
            wen_q        <= 1'b0;
            f3_q         <= '0;
            a_q          <= '0;
            reg_wen      <= 1'b0;
            reg_waddr    <= '0;
            reg_wdata    <= '0;
            misalign_err <= 1'b0;
            bus_err      <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= accept ? 8'd0 : state == WAIT_MEM ? cnt + 8'd1 : cnt;
            reg_wen      <= alu_wr || load_wr;
            misalign_err <= accept && is_mem && mis;
            bus_err      <= timeout_hit;
            if (accept && is_mem) begin
                rd_q  <= ex_rd_idx;
                wen_q <= ex_reg_wen;
                f3_q  <= ex_funct3;
                a_q   <= ex_alu_res[1:0];
            end
            if (alu_wr) begin
                reg_waddr <= ex_rd_idx;
                reg_wdata <= direct_v;
            end else if (load_wr) begin
                reg_waddr <= rd_q;
                reg_wdata <= load_v;
            end
        end
    end
endmodule

// File: tb/tb_wb_unit.sv
// tb_wb_unit: randomized and directed checks of wb_unit against a cycle-level
// behavioural model of the writeback rules.
module tb_wb_unit;
    localparam int TMO = 15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_valid = 1'b0, ex_reg_wen = 1'b0, mem_rvalid = 1'b0;
    logic [4:0]  ex_rd_idx = '0;
    logic [1:0]  ex_wb_sel = '0;
    logic [31:0] ex_alu_res = '0, ex_imm = '0, ex_pc = '0, mem_rdata = '0;
    logic [2:0]  ex_funct3 = '0;
    logic        ex_ready, reg_wen, misalign_err, bus_err;
    logic [4:0]  reg_waddr;
    logic [31:0] reg_wdata;

    int checks = 0, failures = 0;

    bit          busy;
    int          waited;
    logic [4:0]  p_rd;
    bit          p_wen;
    logic [2:0]  p_f3;
    logic [1:0]  p_a;
    bit          e_wen, e_merr, e_berr;
    logic [4:0]  e_waddr;
    logic [31:0] e_wdata;

    wb_unit #(.CPU_WIDTH(32), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_reg_wen(ex_reg_wen), .ex_rd_idx(ex_rd_idx), .ex_wb_sel(ex_wb_sel),
        .ex_alu_res(ex_alu_res), .ex_imm(ex_imm), .ex_pc(ex_pc), .ex_funct3(ex_funct3),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .reg_wen(reg_wen),
        .reg_waddr(reg_waddr), .reg_wdata(reg_wdata), .misalign_err(misalign_err),
        .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] load_val(input logic [2:0] f3, input logic [1:0] a,
                                              input logic [31:0] w);
        int unsigned b, h;
        b = (w >> (8 * a)) & 32'hFF;
        h = (w >> (16 * (a / 2))) & 32'hFFFF;
        case (f3)
            3'b000:  return b >= 128 ? b - 256 : b;
            3'b001:  return h >= 32768 ? h - 65536 : h;
            3'b100:  return b;
            3'b101:  return h;
            default: return w;
        endcase
    endfunction

    function automatic bit bad_align(input logic [2:0] f3, input logic [1:0] a);
        if (f3 == 3'b000 || f3 == 3'b100) return 0;
        if (f3 == 3'b001 || f3 == 3'b101) return a % 2 != 0;
        if (f3 == 3'b010) return a != 0;
        return 1;
    endfunction

    task automatic model_reset();
        busy = 0; waited = 0;
        e_wen = 0; e_merr = 0; e_berr = 0; e_waddr = 0; e_wdata = 0;
    endtask

    // One clock: predict the next-cycle outputs from current inputs, clock, compare.
    task automatic cycle();
        chk("ex_ready", {31'b0, ex_ready}, {31'b0, !busy});
        e_wen = 0; e_merr = 0; e_berr = 0;
        if (!busy && ex_valid) begin
            if (ex_wb_sel != 2'd1) begin
                if (ex_reg_wen && ex_rd_idx != 0) begin
                    e_wen = 1;
                    e_waddr = ex_rd_idx;
                    e_wdata = ex_wb_sel == 0 ? ex_alu_res : ex_wb_sel == 2 ? ex_pc + 4 : ex_imm;
                end
            end else if (bad_align(ex_funct3, ex_alu_res[1:0])) begin
                e_merr = 1;
            end else begin
                busy = 1; waited = 0;
                p_rd = ex_rd_idx; p_wen = ex_reg_wen; p_f3 = ex_funct3; p_a = ex_alu_res[1:0];
            end
        end else if (busy) begin
            if (mem_rvalid) begin
                busy = 0;
                if (p_wen && p_rd != 0) begin
                    e_wen = 1; e_waddr = p_rd; e_wdata = load_val(p_f3, p_a, mem_rdata);
                end
            end else begin
                waited++;
                if (waited == TMO) begin
                    busy = 0; e_berr = 1;
                end
            end
        end
        @(posedge clk); #1;
        chk("reg_wen", {31'b0, reg_wen}, {31'b0, e_wen});
        chk("misalign_err", {31'b0, misalign_err}, {31'b0, e_merr});
        chk("bus_err", {31'b0, bus_err}, {31'b0, e_berr});
        if (e_wen) begin
            chk("reg_waddr", {27'b0, reg_waddr}, {27'b0, e_waddr});
            chk("reg_wdata", reg_wdata, e_wdata);
        end
    endtask

    task automatic nonmem(input logic [1:0] sel, input logic [4:0] rd, input logic [31:0] v);
        ex_valid = 1; ex_reg_wen = 1; ex_rd_idx = rd; ex_wb_sel = sel;
        ex_alu_res = v; ex_imm = v; ex_pc = v; mem_rvalid = 0;
        cycle();
    endtask

    task automatic load(input logic [2:0] f3, input logic [31:0] addr, input logic [4:0] rd);
        ex_valid = 1; ex_reg_wen = 1; ex_rd_idx = rd; ex_wb_sel = 2'd1;
        ex_funct3 = f3; ex_alu_res = addr; mem_rvalid = 0;
        cycle();
    endtask

    task automatic idle(input bit rv);
        ex_valid = 0; mem_rvalid = rv;
        cycle();
    endtask

    task automatic load_resp(input logic [2:0] f3, input logic [1:0] a, input int dly,
                             input string tag, input logic [31:0] want);
        load(f3, {30'h1000, a}, 5'd9);
        for (int i = 1; i < dly; i++) idle(0);
        idle(1);
        chk(tag, reg_wdata, want);
    endtask

    task automatic do_reset();
        #2 rst_n = 0;
        #1;
        chk("rst_outs", {reg_wen, misalign_err, bus_err, reg_waddr, reg_wdata[7:0]}, '0);
        chk("rst_wdata", reg_wdata, 32'h0);
        chk("rst_ready", {31'b0, ex_ready}, 32'h1);
        model_reset();
        @(negedge clk);
        ex_valid = 0; mem_rvalid = 0;
        @(negedge clk) rst_n = 1;
    endtask

    initial begin
        model_reset();
        ex_funct3 = 3'b010;
        repeat (2) @(negedge clk);
        chk("por_ready", {31'b0, ex_ready}, 32'h1);
        chk("por_wen", {31'b0, reg_wen}, 32'h0);
        rst_n = 1;
        @(posedge clk); #1;

        nonmem(2'd0, 5'd5, 32'h1234_5678);
        chk("alu_x5", reg_wdata, 32'h1234_5678);
        nonmem(2'd2, 5'd6, 32'hFFFF_FFFC);
        chk("pc4_wrap", reg_wdata, 32'h0);
        nonmem(2'd3, 5'd7, 32'hABCD_0000);
        nonmem(2'd0, 5'd0, 32'h5555_5555);
        chk("rd0_nowen", {31'b0, reg_wen}, 32'h0);

        mem_rdata = 32'h80FF_7F01;
        load_resp(3'b000, 2'd3, 1, "lb3", 32'hFFFF_FF80);
        load_resp(3'b100, 2'd3, 1, "lbu3", 32'h0000_0080);
        load_resp(3'b001, 2'd2, 5, "lh2", 32'hFFFF_80FF);
        load_resp(3'b101, 2'd0, 1, "lhu0", 32'h0000_7F01);
        load_resp(3'b010, 2'd0, 5, "lw", 32'h80FF_7F01);

        load(3'b001, 32'h0000_0101, 5'd3);
        chk("mis_lh", {31'b0, misalign_err}, 32'h1);
        load(3'b010, 32'h0000_0102, 5'd3);
        chk("mis_lw", {31'b0, misalign_err}, 32'h1);
        load(3'b011, 32'h0000_0100, 5'd3);
        chk("mis_f3", {31'b0, misalign_err}, 32'h1);
        idle(1);

        load(3'b010, 32'h200, 5'd4);
        repeat (TMO) idle(0);
        chk("bus_err_n16", {31'b0, bus_err}, 32'h1);
        chk("tmo_ready", {31'b0, ex_ready}, 32'h1);
        load(3'b010, 32'h200, 5'd4);
        repeat (TMO - 1) idle(0);
        idle(1);
        chk("edge_resp_wen", {31'b0, reg_wen}, 32'h1);
        chk("edge_resp_berr", {31'b0, bus_err}, 32'h0);

        nonmem(2'd0, 5'd10, 32'h1);
        load(3'b010, 32'h300, 5'd11);
        ex_wb_sel = 2'd0; ex_rd_idx = 5'd12; ex_alu_res = 32'h3;
        cycle();
        mem_rvalid = 1; mem_rdata = 32'h2222_2222;
        cycle();
        chk("b2b_lw_idx", {27'b0, reg_waddr}, 32'd11);
        mem_rvalid = 0;
        cycle();
        chk("b2b_alu_idx", {27'b0, reg_waddr}, 32'd12);
        ex_valid = 0;

        load(3'b010, 32'h400, 5'd13);
        idle(0);
        do_reset();
        idle(1);
        chk("drop_pending", {31'b0, reg_wen}, 32'h0);

        for (int n = 0; n < 600; n++) begin
            ex_valid   = $urandom_range(0, 3) != 0;
            ex_reg_wen = $urandom_range(0, 7) != 0;
            ex_rd_idx  = 5'($urandom);
            ex_wb_sel  = 2'($urandom);
            ex_alu_res = $urandom;
            ex_imm     = $urandom;
            ex_pc      = $urandom;
            ex_funct3  = $urandom_range(0, 5) == 0 ? 3'($urandom) :
                         ($urandom_range(0, 1) ? 3'b010 : {1'($urandom), 2'($urandom_range(0, 1))});
            mem_rvalid = $urandom_range(0, 9) < 2 || (n > 300 && $urandom_range(0, 19) == 0);
            mem_rdata  = $urandom;
            if (n % 97 == 50) do_reset();
            else cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/wb_unit.md
# wb_unit

Writeback unit for the rvseed core: the result-side counterpart of the ALU operand selection. It accepts one retiring instruction per handshake from execute, selects the writeback source (ALU result, load data, pc+4, or immediate), aligns and sign/zero-extends load data, waits for the data-memory response with a timeout, and issues a single-cycle registered write to the register file.

## Interface
- `CPU_WIDTH`, default 32: datapath width; only 32 is supported.
- `TIMEOUT`, default 15: maximum cycles spent in WAIT_MEM before a bus error; range 1–255.
- `clk` input 1: clock, rising edge.
- `rst_n` input 1: reset; asynchronous assert, active-low.
- `ex_valid` input 1: execute presents a retiring instruction.
- `ex_ready` output 1: unit can accept an instruction.
- `ex_reg_wen` input 1: the instruction writes rd.
- `ex_rd_idx` input 5: destination register index.
- `ex_wb_sel` input 2: 0=ALU, 1=MEM, 2=PC4, 3=IMM.
- `ex_alu_res` input CPU_WIDTH: ALU result; for loads, the effective address.
- `ex_imm` input CPU_WIDTH: immediate (LUI path).
- `ex_pc` input CPU_WIDTH: instruction pc.
- `ex_funct3` input 3: load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- `mem_rvalid` input 1: data-memory read response valid.
- `mem_rdata` input CPU_WIDTH: aligned word at `{addr[31:2],2'b00}`.
- `reg_wen` output 1: register-file write enable, one-cycle pulse.
- `reg_waddr` output 5: write index.
- `reg_wdata` output CPU_WIDTH: write data.
- `misalign_err` output 1: one-cycle pulse on a misaligned load.
- `bus_err` output 1: one-cycle pulse on a memory timeout.

## Operation
- **States:** IDLE and WAIT_MEM. `ex_ready = (state==IDLE)`.
- **Accept:** an instruction is accepted when `ex_valid && ex_ready`.
- **Non-MEM accept:**
  - Data is ALU = `ex_alu_res`, PC4 = `ex_pc + 4` (mod 2^32), IMM = `ex_imm`.
  - Data is registered to `reg_wdata`/`reg_waddr` on the next edge.
  - `reg_wen` is asserted for one cycle iff `ex_reg_wen && ex_rd_idx!=0`.
  - State stays IDLE.
- **MEM accept:**
  - Capture rd, wen, funct3 and `ex_alu_res[1:0]`.
  - Misaligned cases: LH/LHU with addr[0]=1, or LW with addr[1:0]!=0, or an unsupported funct3 (011, 110, 111). For these, pulse `misalign_err` next cycle, perform no write, and stay IDLE.
  - Otherwise go to WAIT_MEM and clear the timeout counter.
- **WAIT_MEM, `mem_rvalid`=1:**
  - Select the byte `mem_rdata[8*a+:8]` or the half `mem_rdata[16*a[1]+:16]`.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
  - Register the result and pulse `reg_wen` next cycle (suppressed if rd=0 or wen=0).
  - Return to IDLE.
- **WAIT_MEM, no response:**
  - The counter increments each cycle.
  - When the counter reaches TIMEOUT with no `mem_rvalid`, pulse `bus_err` next cycle, perform no write, and return to IDLE.
  - A `mem_rvalid` in the same cycle the counter hits TIMEOUT takes priority: the write happens and there is no error.
- **Ignored responses:** `mem_rvalid` while in IDLE is ignored and has no effect.
- **Reset (any time, including mid-WAIT_MEM):**
  - state=IDLE, counter=0.
  - `reg_wen`=0, `reg_waddr`=0, `reg_wdata`=0, `misalign_err`=0, `bus_err`=0.
  - Any pending load is dropped.
- `reg_waddr`/`reg_wdata` hold their last value when `reg_wen`=0.

## Timing
- **Non-MEM:** accept in cycle N → `reg_wen` high in cycle N+1; the next accept is possible in cycle N+1 (throughput 1/cycle).
- **MEM:** accept in cycle N → `ex_ready`=0 from N+1.
  - The earliest valid response is in cycle N+1; a response at cycle M gives `reg_wen` at M+1.
  - `ex_ready` returns to 1 in M+1, so an accept in M+1 is allowed and back-to-back writes are pulsed in consecutive cycles.
- **Timeout:** with no response, the error pulses in cycle N+1+TIMEOUT and `ex_ready` is 1 in that same cycle.
- **Misalignment:** the error pulses in N+1 and `ex_ready` never drops.
- All outputs are registered; there is no combinational path from `mem_rdata` to `reg_wdata`.

## Test plan
- **Reset:** assert `rst_n`=0 mid-stream → all outputs 0, `ex_ready`=1; a pending LW issued before reset produces no write after release.
- **Non-MEM writes:**
  - ALU: x5 with `ex_alu_res`=0x1234_5678 → next cycle `reg_wen`=1, waddr=5, wdata=0x1234_5678.
  - PC4: pc=0xFFFF_FFFC → wdata=0x0000_0000.
  - rd=0 → `reg_wen` stays 0.
- **Load extension:** `mem_rdata`=0x80FF_7F01.
  - LB at addr[1:0]=3 → 0xFFFF_FF80; LBU at addr 3 → 0x0000_0080.
  - LH at addr 2 → 0xFFFF_80FF; LHU at addr 0 → 0x0000_7F01.
  - LW → 0x80FF_7F01.
  - Response delays of 1 and 5 cycles → write 1 cycle after `mem_rvalid`.
- **Misalignment:** LH at addr 0x...01, LW at 0x...02 → `misalign_err` pulse, no write, `ex_ready` stays 1; funct3=011 behaves the same.
- **Timeout, TIMEOUT=15:**
  - No response → `bus_err` in cycle N+16, no write, IDLE.
  - Response exactly at the TIMEOUT cycle → write, no `bus_err`.
  - A stray `mem_rvalid` in IDLE → no effect.
- **Back-to-back:** ALU, LW (2-cycle delay), ALU issued with `ex_valid` held high → three writes in order with correct indices, and `ex_ready` low only during WAIT_MEM.
